ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
- Shares one ULA instance between two requesters, e.g. the main datapath and a branch/address helper.
- Accepts operations over per-requester valid/ready handshakes and drives the ULA from registered operands.
- Captures ULA result and Z, and returns them on a per-requester response handshake.
- Grants are round-robin; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width (must match ULA SrcA/SrcB/ULAResult).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_op  in  3  ULA control code
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
rsp0_valid  out  1  response for requester 0 available
rsp0_ready  in  1  requester 0 consumes response
rsp0_result  out  WIDTH  captured ULA result
rsp0_z  out  1  captured ULA zero flag
rsp0_err  out  1  op code was illegal (100 or 101)
rsp1_valid, rsp1_ready, rsp1_result, rsp1_z, rsp1_err  same as requester 0, for requester 1
ula_srca  out  WIDTH  to ULA SrcA
ula_srcb  out  WIDTH  to ULA SrcB
ula_ctrl  out  3  to ULA ULAControl
ula_result  in  WIDTH  from ULA ULAResult
ula_z  in  1  from ULA Z
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pri=0 (requester 0 favoured).
  - ula_srca/ula_srcb/ula_ctrl=0.
  - All rsp* outputs 0, all req*_ready 0, busy 0.
  - Any in-flight operation is discarded; no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational and asserted for at most one requester: the winner.
  - Winner rule: if only one valid, that requester; if both valid, requester pri.
  - On the edge where winner valid&&ready:
    - load ula_srca/ula_srcb/ula_ctrl from winner's a/b/op;
    - record owner and err = (op==100 || op==101);
    - set pri = other requester;
    - go to EXEC.
  - No valid: stay in IDLE, pri unchanged.
- EXEC: exactly one cycle; at the next edge latch ula_result and ula_z into the owner's rsp_result/rsp_z, latch rsp_err, go to RESP.
- RESP:
  - rsp<owner>_valid=1; result/z/err held stable.
  - Go to IDLE on the edge where rsp<owner>_ready=1.
  - Hold indefinitely otherwise (backpressure); both req*_ready=0 throughout.
  - The non-owner rsp_valid stays 0.
- rsp*_valid drops in IDLE; rsp*_result/z/err keep their last value until overwritten.
- Latency:
  - accept edge k -> rsp_valid high after edge k+1;
  - with rsp_ready tied high, next accept earliest at edge k+3 (one op per 3 cycles).
- ula_* outputs are registered and change only at accept edges; they hold between operations.
- Illegal op codes are forwarded unchanged to the ULA; the arbiter does not alter result or Z, and only flags err.
- Op codes:
  - 000 AND, 001 OR, 010 ADD, 011 NOR, 110 SUB, 111 SLT (unsigned, result 1/0).
  - Wrap-around is modulo 2^WIDTH.
- A requester may drop valid before being granted; no state change results.
- The arbiter does not require requesters to hold valid.

Test Plan:
1. Reset, then req0 valid, op=010, a=0x05, b=0x03 -> req0_ready=1 that cycle; ula_srca=0x05, ula_ctrl=010 after edge; rsp0_valid after next edge with result 0x08, z=0, err=0.
2. Both valid in the same cycle after reset; req0 SUB 0x03-0x05, req1 SLT 0x02,0x07 -> req0 granted first with rsp0_result 0xFE, z=0; then req1 with rsp1_result 0x01, z=0; pri alternates.
3. req0 held valid continuously with SUB 0x2A-0x2A, req1 valid after first grant -> second grant goes to req1 (round-robin); rsp0 result 0x00, z=1.
4. Backpressure: rsp0_ready low 4 cycles during RESP -> rsp0_valid stays 1, result stable, req0_ready/req1_ready 0, busy 1; IDLE reached on the edge rsp0_ready rises.
5. req1 op=100, a=0xFF, b=0x01 -> rsp1_err=1, rsp1_result=0x00, rsp1_z=1.
6. Assert rst_n low during EXEC -> outputs zero immediately; no rsp*_valid after release; next request served normally with pri=0.

Source files
------------

// File: rtl/ula_arbiter_if.sv
// Bus bundle between ula_arbiter, its two requesters and the shared ULA.
// slave: the arbiter's view. master: the requesters/ULA view.
interface ula_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_z;
  logic             rsp0_err;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_z;
  logic             rsp1_err;

  logic [WIDTH-1:0] ula_srca;
  logic [WIDTH-1:0] ula_srcb;
  logic [2:0]       ula_ctrl;
  logic [WIDTH-1:0] ula_result;
  logic             ula_z;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    input  ula_result, ula_z,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_z, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_z, rsp1_err,
    output ula_srca, ula_srcb, ula_ctrl,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    output ula_result, ula_z,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_z, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_z, rsp1_err,
    input  ula_srca, ula_srcb, ula_ctrl,
    input  busy
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ULA between two requesters. One operation in
// flight: accept (IDLE) -> one ULA cycle (EXEC) -> response held until taken (RESP).
module ula_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  ula_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic             pri_q;    // requester favoured when both are valid
  logic             owner_q;  // requester of the operation in flight
  logic             err_q;    // illegal op flag for the operation in flight
  logic [WIDTH-1:0] srca_q;
  logic [WIDTH-1:0] srcb_q;
  logic [2:0]       ctrl_q;
  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_z_q;
  logic [1:0]       rsp_err_q;
  logic [WIDTH-1:0] rsp_result_q [2];

  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [2:0]       win_op;
  logic             owner_rsp_ready;

  // Winner selection in IDLE; gated by rst_n so ready stays low during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && rst_n) begin
      if (bus.req0_valid && (!bus.req1_valid || !pri_q)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_a           = grant1 ? bus.req1_a  : bus.req0_a;
    win_b           = grant1 ? bus.req1_b  : bus.req0_b;
    win_op          = grant1 ? bus.req1_op : bus.req0_op;
    owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  // Control FSM with registered ULA operands and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      pri_q           <= 1'b0;
      owner_q         <= 1'b0;
      err_q           <= 1'b0;
      srca_q          <= '0;
      srcb_q          <= '0;
      ctrl_q          <= '0;
      rsp_valid_q     <= '0;
      rsp_z_q         <= '0;
      rsp_err_q       <= '0;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            srca_q  <= win_a;
            srcb_q  <= win_b;
            ctrl_q  <= win_op;
            owner_q <= grant1;
            err_q   <= (win_op == 3'b100) || (win_op == 3'b101);
            pri_q   <= ~grant1;
            state_q <= StExec;
          end
        end
        StExec: begin
          // The ULA is combinational on the registered operands: capture now.
          rsp_result_q[owner_q] <= bus.ula_result;
          rsp_z_q[owner_q]      <= bus.ula_z;
          rsp_err_q[owner_q]    <= err_q;
          rsp_valid_q[owner_q]  <= 1'b1;
          state_q               <= StResp;
        end
        StResp: begin
          if (owner_rsp_ready) begin
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = rsp_result_q[0];
  assign bus.rsp1_result = rsp_result_q[1];
  assign bus.rsp0_z      = rsp_z_q[0];
  assign bus.rsp1_z      = rsp_z_q[1];
  assign bus.rsp0_err    = rsp_err_q[0];
  assign bus.rsp1_err    = rsp_err_q[1];
  assign bus.ula_srca    = srca_q;
  assign bus.ula_srcb    = srcb_q;
  assign bus.ula_ctrl    = ctrl_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: single-op vector table, hand-written
// multi-cycle sequences, then random traffic against a transaction-level model.
module tb_ula_arbiter;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ula_arbiter_if #(.WIDTH(W)) bus ();
  ula_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference ULA behaviour; illegal codes give 0.
  function automatic logic [W-1:0] ula_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return ~(a | b);
      3'b110:  return a - b;
      3'b111:  return (a < b) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  // Behavioural ULA attached to the arbiter.
  always_comb begin
    logic [W-1:0] r;
    r              = ula_f(bus.ula_srca, bus.ula_srcb, bus.ula_ctrl);
    bus.ula_result = r;
    bus.ula_z      = (r == '0);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input bit who, input bit v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op);
    if (who) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  function automatic logic rdy_of(input bit who);
    return who ? bus.req1_ready : bus.req0_ready;
  endfunction
  function automatic logic vld_of(input bit who);
    return who ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction
  function automatic logic [W-1:0] res_of(input bit who);
    return who ? bus.rsp1_result : bus.rsp0_result;
  endfunction
  function automatic logic z_of(input bit who);
    return who ? bus.rsp1_z : bus.rsp0_z;
  endfunction
  function automatic logic err_of(input bit who);
    return who ? bus.rsp1_err : bus.rsp0_err;
  endfunction

  task automatic idle_inputs();
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    set_req(1'b1, 1'b0, '0, '0, 3'b000);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with a request pending, check every output, release on a negedge.
  task automatic do_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_srca", bus.ula_srca, 0);
    check("rst_srcb", bus.ula_srcb, 0);
    check("rst_ctrl", bus.ula_ctrl, 0);
    check("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    check("rst_rsp_result", {bus.rsp1_result, bus.rsp0_result}, 0);
    check("rst_rsp_flags", {bus.rsp1_z, bus.rsp0_z, bus.rsp1_err, bus.rsp0_err}, 0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit           who;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
    bit           z;
    bit           err;
  } vec_t;

  vec_t vecs[9];

  // One isolated transaction, entered and left on a negedge with arbiter idle.
  task automatic run_single(input vec_t v);
    set_req(v.who, 1'b1, v.a, v.b, v.op);
    #1;
    check("vec_ready_winner", rdy_of(v.who), 1);
    check("vec_ready_other", rdy_of(!v.who), 0);
    step();
    set_req(v.who, 1'b0, '0, '0, 3'b000);
    check("vec_ula_srca", bus.ula_srca, v.a);
    check("vec_ula_srcb", bus.ula_srcb, v.b);
    check("vec_ula_ctrl", bus.ula_ctrl, v.op);
    check("vec_busy_exec", bus.busy, 1);
    check("vec_rsp_early", vld_of(v.who), 0);
    step();
    check("vec_rsp_valid", vld_of(v.who), 1);
    check("vec_rsp_other", vld_of(!v.who), 0);
    check("vec_result", res_of(v.who), v.res);
    check("vec_z", z_of(v.who), v.z);
    check("vec_err", err_of(v.who), v.err);
    step();
    check("vec_busy_done", bus.busy, 0);
    check("vec_rsp_drop", vld_of(v.who), 0);
    @(negedge clk);
  endtask

  typedef struct {
    bit           who;
    logic [W-1:0] res;
    bit           z;
    bit           err;
    int           age;
  } txn_t;

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    vecs[0] = '{1'b0, 8'h05, 8'h03, 3'b010, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 8'h01, 3'b100, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 8'hF0, 8'h0F, 3'b000, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'hF0, 8'h0F, 3'b001, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 3'b010, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h0F, 8'hF0, 3'b011, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h07, 8'h02, 3'b111, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'h00, 8'h01, 3'b110, 8'hFF, 0, 1'b0};
    vecs[8] = '{1'b0, 8'h12, 8'h34, 3'b101, 8'h00, 1'b1, 1'b1};

    do_reset();
    foreach (vecs[i]) run_single(vecs[i]);

    // Both valid after reset: req0 first, then req1.
    do_reset();
    set_req(1'b0, 1'b1, 8'h03, 8'h05, 3'b110);
    set_req(1'b1, 1'b1, 8'h02, 8'h07, 3'b111);
    #1;
    check("both_ready0", bus.req0_ready, 1);
    check("both_ready1", bus.req1_ready, 0);
    step();
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    check("both_ctrl0", bus.ula_ctrl, 3'b110);
    step();
    check("both_rsp0", {bus.rsp0_valid, bus.rsp0_result, bus.rsp0_z}, {1'b1, 8'hFE, 1'b0});
    check("both_req1_blocked", bus.req1_ready, 0);
    step();
    check("both_ready1_later", bus.req1_ready, 1);
    step();
    set_req(1'b1, 1'b0, '0, '0, 3'b000);
    check("both_ctrl1", bus.ula_ctrl, 3'b111);
    step();
    check("both_rsp1", {bus.rsp1_valid, bus.rsp1_result, bus.rsp1_z}, {1'b1, 8'h01, 1'b0});
    check("both_rsp0_idle", bus.rsp0_valid, 0);
    @(negedge clk);
    @(negedge clk);

    // req0 held valid: req1 gets the next grant.
    set_req(1'b0, 1'b1, 8'h2A, 8'h2A, 3'b110);
    #1;
    check("rr_ready0", bus.req0_ready, 1);
    step();
    set_req(1'b1, 1'b1, 8'h01, 8'h02, 3'b010);
    step();
    check("rr_rsp0", {bus.rsp0_valid, bus.rsp0_result, bus.rsp0_z}, {1'b1, 8'h00, 1'b1});
    step();
    check("rr_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
    step();
    set_req(1'b1, 1'b0, '0, '0, 3'b000);
    check("rr_srca1", bus.ula_srca, 8'h01);
    step();
    check("rr_rsp1", {bus.rsp1_valid, bus.rsp1_result}, {1'b1, 8'h03});
    step();
    check("rr_ready0_again", bus.req0_ready, 1);
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    step();
    check("rr_drop_no_accept", bus.busy, 0);
    @(negedge clk);

    // Backpressure on rsp0 for 4 cycles.
    bus.rsp0_ready = 1'b0;
    set_req(1'b0, 1'b1, 8'h10, 8'h20, 3'b001);
    step();
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    set_req(1'b1, 1'b1, 8'h00, 8'h00, 3'b000);
    step();
    for (int i = 0; i < 4; i++) begin
      check("bp_hold", {bus.rsp0_valid, bus.rsp0_result, bus.busy}, {1'b1, 8'h30, 1'b1});
      check("bp_ready", {bus.req1_ready, bus.req0_ready, bus.rsp1_valid}, 0);
      step();
    end
    bus.rsp0_ready = 1'b1;
    check("bp_still_valid", bus.rsp0_valid, 1);
    step();
    check("bp_release", {bus.busy, bus.rsp0_valid}, 0);
    check("bp_req1_ready", bus.req1_ready, 1);
    set_req(1'b1, 1'b0, '0, '0, 3'b000);
    @(negedge clk);

    // Reset during EXEC discards the operation; pri returns to requester 0.
    set_req(1'b1, 1'b1, 8'h05, 8'h06, 3'b010);
    step();
    set_req(1'b1, 1'b0, '0, '0, 3'b000);
    check("rx_busy_exec", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rx_zero", {bus.busy, bus.ula_srca, bus.ula_ctrl, bus.rsp1_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rx_no_rsp", {bus.rsp1_valid, bus.rsp0_valid, bus.busy}, 0);
    end
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'h09, 8'h01, 3'b110);
    set_req(1'b1, 1'b1, 8'h01, 8'h01, 3'b010);
    #1;
    check("rx_pri0", {bus.req1_ready, bus.req0_ready}, 2'b01);
    step();
    idle_inputs();
    step();
    check("rx_rsp0", {bus.rsp0_valid, bus.rsp0_result}, {1'b1, 8'h08});
    @(negedge clk);
    @(negedge clk);

    // Random traffic against a transaction-level model.
    do_reset();
    begin
      txn_t         q[$];
      bit           m_pri = 1'b0;
      logic [W-1:0] m_a = '0;
      logic [W-1:0] m_b = '0;
      logic [2:0]   m_op = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit has_w;
        bit w;
        bit rr[2];
        logic [W-1:0] a[2];
        logic [W-1:0] b[2];
        logic [2:0]   op[2];
        bit           v[2];
        for (int k = 0; k < 2; k++) begin
          v[k]  = ($urandom_range(0, 2) != 0);
          a[k]  = W'($urandom);
          b[k]  = ($urandom_range(0, 3) == 0) ? a[k] : W'($urandom);
          op[k] = 3'($urandom);
          rr[k] = ($urandom_range(0, 9) < 6);
          set_req(k[0], v[k], a[k], b[k], op[k]);
        end
        bus.rsp0_ready = rr[0];
        bus.rsp1_ready = rr[1];
        #1;
        has_w = 1'b0;
        w     = 1'b0;
        if (q.size() == 0) begin
          if (v[0] && v[1]) begin has_w = 1'b1; w = m_pri; end
          else if (v[0])    begin has_w = 1'b1; w = 1'b0; end
          else if (v[1])    begin has_w = 1'b1; w = 1'b1; end
        end
        check("rnd_ready", {bus.req1_ready, bus.req0_ready},
              {has_w && w, has_w && !w});
        check("rnd_busy", bus.busy, q.size() != 0);
        check("rnd_ula", {bus.ula_srca, bus.ula_srcb, bus.ula_ctrl}, {m_a, m_b, m_op});
        if (q.size() != 0 && q[0].age >= 1) begin
          check("rnd_rsp_valid", {vld_of(q[0].who), vld_of(!q[0].who)}, 2'b10);
          check("rnd_rsp_data", {res_of(q[0].who), z_of(q[0].who), err_of(q[0].who)},
                {q[0].res, q[0].z, q[0].err});
        end else begin
          check("rnd_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        end
        // Model advance for the coming edge.
        if (q.size() == 0) begin
          if (has_w) begin
            txn_t t;
            t.who = w;
            t.res = ula_f(a[w], b[w], op[w]);
            t.z   = (t.res == '0);
            t.err = (op[w] == 3'b100) || (op[w] == 3'b101);
            t.age = 0;
            q.push_back(t);
            m_a   = a[w];
            m_b   = b[w];
            m_op  = op[w];
            m_pri = !w;
          end
        end else if (q[0].age >= 1 && rr[q[0].who]) begin
          void'(q.pop_front());
        end else begin
          q[0].age++;
        end
        @(negedge clk);
      end
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
